keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner_if.sv | 35 +++
 rtl/keypad_scanner.sv | 249 ++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and decoded-key signal bundle
interface keypad_scanner_if;
  logic [2:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_press;
  logic       key_release;
  logic       star_pressed;
  logic       key_clk;

  // Scanner side: reads the columns, drives the rows and the decoded key
  modport master (
    input  col,
    output row,
    output key_code,
    output key_valid,
    output key_press,
    output key_release,
    output star_pressed,
    output key_clk
  );

  // Keypad/consumer side
  modport slave (
    output col,
    input  row,
    input  key_code,
    input  key_valid,
    input  key_press,
    input  key_release,
    input  star_pressed,
    input  key_clk
  );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 matrix keypad scanner with press/release debounce
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  keypad_scanner_if.master kp
);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_e;

  localparam logic [15:0] DWELL_LAST   = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  AGREE_TARGET = 4'(DEBOUNCE_CNT);
  localparam logic [3:0]  CODE_STAR    = 4'd10;
  localparam logic [2:0]  COLS_IDLE    = 3'b111;

  // Column synchronizer
  logic [2:0]  col_meta_q;
  logic [2:0]  col_sync_q;

  // Row dwell timing
  logic [15:0] div_q;
  logic [15:0] div_d;
  logic        dwell_end;

  // Scan / debounce state
  state_e      state_q;
  logic [3:0]  row_q;
  logic [1:0]  row_idx_q;
  logic [2:0]  pat_q;
  logic [3:0]  agree_q;
  logic [3:0]  agree_d;
  logic [3:0]  lat_code_q;

  // Registered outputs
  logic [3:0]  key_code_q;
  logic        key_valid_q;
  logic        key_press_q;
  logic        key_release_q;
  logic        star_q;
  logic        key_clk_q;

  // Sample decode
  logic        single_low_d;
  logic        all_high_d;
  logic [1:0]  col_idx_d;
  logic [3:0]  scan_code_d;
  logic [3:0]  accept_code_d;
  logic        agree_done_d;

  // Row r, column c -> key code; the bottom row carries *, 0 and #
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'd0;
    if (r == 2'd3) begin
      case (c)
        2'd0:    code = CODE_STAR;
        2'd1:    code = 4'd0;
        default: code = 4'd11;
      endcase
    end else begin
      code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    end
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous column inputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_meta_q <= COLS_IDLE;
      col_sync_q <= COLS_IDLE;
    end else begin
      col_meta_q <= kp.col;
      col_sync_q <= col_meta_q;
    end
  end

  // Dwell counter: wraps after SCAN_DIV-1, the last clock of a dwell is the sample point
  always_comb begin
    div_d = div_q + 16'd1;
    if (dwell_end) begin
      div_d = 16'd0;
    end
  end

  assign dwell_end = (div_q == DWELL_LAST);

  // Dwell counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= 16'd0;
    end else begin
      div_q <= div_d;
    end
  end

  // Classify the synchronized sample and precompute the debounce step
  always_comb begin
    single_low_d = 1'b0;
    col_idx_d    = 2'd0;
    case (col_sync_q)
      3'b110: begin
        single_low_d = 1'b1;
        col_idx_d    = 2'd0;
      end
      3'b101: begin
        single_low_d = 1'b1;
        col_idx_d    = 2'd1;
      end
      3'b011: begin
        single_low_d = 1'b1;
        col_idx_d    = 2'd2;
      end
      default: begin
        single_low_d = 1'b0;
        col_idx_d    = 2'd0;
      end
    endcase
    all_high_d    = (col_sync_q == COLS_IDLE);
    scan_code_d   = map_key(row_idx_q, col_idx_d);
    // With a one-sample debounce the key is accepted straight out of SCAN
    accept_code_d = (state_q == ST_SCAN) ? scan_code_d : lat_code_q;
    agree_d       = agree_q + 4'd1;
    agree_done_d  = (agree_d >= AGREE_TARGET);
  end

  // Scan/debounce FSM with registered row drive and key outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_SCAN;
      row_q         <= 4'b1110;
      row_idx_q     <= 2'd0;
      pat_q         <= COLS_IDLE;
      agree_q       <= 4'd0;
      lat_code_q    <= 4'd0;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      star_q        <= 1'b0;
      key_clk_q     <= 1'b0;
    end else begin
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      if (dwell_end) begin
        case (state_q)
          ST_SCAN: begin
            if (single_low_d) begin
              pat_q      <= col_sync_q;
              lat_code_q <= scan_code_d;
              if (agree_done_d) begin
                state_q     <= ST_HELD;
                agree_q     <= 4'd0;
                key_code_q  <= accept_code_d;
                key_valid_q <= 1'b1;
                key_press_q <= 1'b1;
                star_q      <= (accept_code_d == CODE_STAR);
                key_clk_q   <= (accept_code_d != CODE_STAR);
              end else begin
                state_q <= ST_DEBOUNCE;
                agree_q <= agree_d;
              end
            end else begin
              row_q     <= {row_q[2:0], row_q[3]};
              row_idx_q <= row_idx_q + 2'd1;
            end
          end
          ST_DEBOUNCE: begin
            if (col_sync_q == pat_q) begin
              if (agree_done_d) begin
                state_q     <= ST_HELD;
                agree_q     <= 4'd0;
                key_code_q  <= accept_code_d;
                key_valid_q <= 1'b1;
                key_press_q <= 1'b1;
                star_q      <= (accept_code_d == CODE_STAR);
                key_clk_q   <= (accept_code_d != CODE_STAR);
              end else begin
                agree_q <= agree_d;
              end
            end else begin
              // Bounce: abandon this key silently and move on
              state_q   <= ST_SCAN;
              agree_q   <= 4'd0;
              row_q     <= {row_q[2:0], row_q[3]};
              row_idx_q <= row_idx_q + 2'd1;
            end
          end
          ST_HELD: begin
            // Anything other than all-high (including a second key) keeps the key held
            if (all_high_d) begin
              if (agree_done_d) begin
                state_q       <= ST_SCAN;
                agree_q       <= 4'd0;
                key_valid_q   <= 1'b0;
                key_release_q <= 1'b1;
                star_q        <= 1'b0;
                key_clk_q     <= 1'b0;
                row_q         <= {row_q[2:0], row_q[3]};
                row_idx_q     <= row_idx_q + 2'd1;
              end else begin
                state_q <= ST_RELEASE;
                agree_q <= agree_d;
              end
            end
          end
          ST_RELEASE: begin
            if (all_high_d) begin
              if (agree_done_d) begin
                state_q       <= ST_SCAN;
                agree_q       <= 4'd0;
                key_valid_q   <= 1'b0;
                key_release_q <= 1'b1;
                star_q        <= 1'b0;
                key_clk_q     <= 1'b0;
                row_q         <= {row_q[2:0], row_q[3]};
                row_idx_q     <= row_idx_q + 2'd1;
              end else begin
                agree_q <= agree_d;
              end
            end else begin
              state_q <= ST_HELD;
              agree_q <= 4'd0;
            end
          end
          default: begin
            state_q <= ST_SCAN;
            agree_q <= 4'd0;
          end
        endcase
      end
    end
  end

  assign kp.row          = row_q;
  assign kp.key_code     = key_code_q;
  assign kp.key_valid    = key_valid_q;
  assign kp.key_press    = key_press_q;
  assign kp.key_release  = key_release_q;
  assign kp.star_pressed = star_q;
  assign kp.key_clk      = key_clk_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - bench for keypad_scanner with keypad model and per-dwell reference
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 3;

  localparam int PH_SCAN = 0;
  localparam int PH_DEB  = 1;
  localparam int PH_HELD = 2;
  localparam int PH_REL  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_if kif();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif)
  );

  // Physical keypad: a pressed key shorts its row line onto its column line
  logic        force_en  = 1'b0;
  logic [2:0]  col_force = 3'b111;
  logic [11:0] key_mask  = 12'h000;
  logic [2:0]  keypad_cols;

  always_comb begin
    keypad_cols = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!kif.row[r] && key_mask[r*3+c]) keypad_cols[c] = 1'b0;
  end

  assign kif.col = force_en ? col_force : keypad_cols;

  int n_pass = 0;
  int n_total = 0;
  int press_seen = 0;
  int release_seen = 0;

  // Reference model, advanced once per dwell
  int   m_phase, m_row, m_cnt, m_code, m_lat;
  logic [2:0] m_pat;
  bit   m_valid, exp_press, exp_release;
  int   keymap [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

  typedef struct {
    logic [11:0] mask;
    int          code;
    int          star;
    int          kclk;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, req);
  endtask

  function automatic logic [2:0] model_cols(input logic [11:0] mask, input int r);
    logic [2:0] c;
    c = 3'b111;
    for (int i = 0; i < 3; i++) if (mask[r*3+i]) c[i] = 1'b0;
    return c;
  endfunction

  task automatic model_reset();
    m_phase = PH_SCAN; m_row = 0; m_cnt = 0; m_code = 0; m_lat = 0;
    m_pat = 3'b111; m_valid = 0; exp_press = 0; exp_release = 0;
  endtask

  task automatic model_step(input logic [2:0] s);
    int lows, ci;
    lows = 0; ci = 0;
    for (int i = 0; i < 3; i++) if (!s[i]) begin lows++; ci = i; end
    case (m_phase)
      PH_SCAN: begin
        if (lows == 1) begin
          m_pat = s; m_lat = keymap[m_row*3+ci]; m_cnt = 1;
          if (m_cnt >= DC) begin m_phase = PH_HELD; m_valid = 1; m_code = m_lat; exp_press = 1; end
          else m_phase = PH_DEB;
        end else m_row = (m_row + 1) % 4;
      end
      PH_DEB: begin
        if (s == m_pat) begin
          m_cnt++;
          if (m_cnt >= DC) begin m_phase = PH_HELD; m_valid = 1; m_code = m_lat; exp_press = 1; end
        end else begin
          m_phase = PH_SCAN; m_row = (m_row + 1) % 4;
        end
      end
      PH_HELD: begin
        if (s == 3'b111) begin
          m_cnt = 1;
          if (m_cnt >= DC) begin m_phase = PH_SCAN; m_valid = 0; m_row = (m_row + 1) % 4; exp_release = 1; end
          else m_phase = PH_REL;
        end
      end
      default: begin
        if (s == 3'b111) begin
          m_cnt++;
          if (m_cnt >= DC) begin m_phase = PH_SCAN; m_valid = 0; m_row = (m_row + 1) % 4; exp_release = 1; end
        end else begin
          m_phase = PH_HELD; m_cnt = 0;
        end
      end
    endcase
  endtask

  // One full dwell of SD clocks; outputs compared to the model after every edge
  task automatic run_dwell(input bit use_force, input logic [2:0] frc, input logic [11:0] mask);
    logic [3:0] er;
    logic [2:0] s;
    force_en = use_force; col_force = frc; key_mask = mask;
    for (int k = 1; k <= SD; k++) begin
      @(posedge clk); #1;
      exp_press = 0; exp_release = 0;
      if (k == SD) begin
        s = use_force ? frc : model_cols(mask, m_row);
        model_step(s);
      end
      if (kif.key_press) press_seen++;
      if (kif.key_release) release_seen++;
      er = 4'b1111; er[m_row] = 1'b0;
      chk("row", int'(kif.row), int'(er));
      chk("key_valid", int'(kif.key_valid), int'(m_valid));
      if (m_valid) chk("key_code", int'(kif.key_code), m_code);
      chk("star_pressed", int'(kif.star_pressed), int'(m_valid && m_code == 10));
      chk("key_clk", int'(kif.key_clk), int'(m_valid && m_code != 10));
      chk("key_press", int'(kif.key_press), int'(exp_press));
      chk("key_release", int'(kif.key_release), int'(exp_release));
    end
  endtask

  task automatic hold_until_valid(input logic [11:0] mask);
    for (int d = 0; d < 24 && !m_valid; d++) run_dwell(1'b0, 3'b111, mask);
  endtask

  task automatic release_all();
    for (int d = 0; d < 24 && m_valid; d++) run_dwell(1'b0, 3'b111, 12'h000);
  endtask

  initial begin
    int p0, r0, sel, len, d;
    logic [11:0] mask;

    vecs[0]  = '{12'h001, 1, 0, 1};
    vecs[1]  = '{12'h002, 2, 0, 1};
    vecs[2]  = '{12'h004, 3, 0, 1};
    vecs[3]  = '{12'h008, 4, 0, 1};
    vecs[4]  = '{12'h010, 5, 0, 1};
    vecs[5]  = '{12'h020, 6, 0, 1};
    vecs[6]  = '{12'h040, 7, 0, 1};
    vecs[7]  = '{12'h080, 8, 0, 1};
    vecs[8]  = '{12'h100, 9, 0, 1};
    vecs[9]  = '{12'h200, 10, 1, 0};
    vecs[10] = '{12'h400, 0, 0, 1};
    vecs[11] = '{12'h800, 11, 0, 1};

    // Reset state
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_row", int'(kif.row), 4'b1110);
    chk("rst_code", int'(kif.key_code), 0);
    chk("rst_valid", int'(kif.key_valid), 0);
    chk("rst_press", int'(kif.key_press), 0);
    chk("rst_release", int'(kif.key_release), 0);
    chk("rst_star", int'(kif.star_pressed), 0);
    chk("rst_key_clk", int'(kif.key_clk), 0);
    reset = 1'b1;

    // Every key: accept, check decode, release
    for (int i = 0; i < 12; i++) begin
      p0 = press_seen; r0 = release_seen;
      hold_until_valid(vecs[i].mask);
      chk("tbl_valid", int'(kif.key_valid), 1);
      chk("tbl_code", int'(kif.key_code), vecs[i].code);
      chk("tbl_star", int'(kif.star_pressed), vecs[i].star);
      chk("tbl_key_clk", int'(kif.key_clk), vecs[i].kclk);
      chk("tbl_press_count", press_seen - p0, 1);
      release_all();
      chk("tbl_released", int'(kif.key_valid), 0);
      chk("tbl_release_count", release_seen - r0, 1);
      chk("tbl_star_after", int'(kif.star_pressed), 0);
    end

    // Bounce: one low sample, one high sample, five times
    p0 = press_seen;
    for (int i = 0; i < 5; i++) begin
      run_dwell(1'b1, 3'b101, 12'h000);
      run_dwell(1'b1, 3'b111, 12'h000);
    end
    chk("bounce_press", press_seen - p0, 0);
    chk("bounce_valid", int'(kif.key_valid), 0);

    // Two columns low on row 0
    p0 = press_seen;
    for (int i = 0; i < 8; i++) run_dwell(1'b0, 3'b111, 12'h003);
    chk("twocol_press", press_seen - p0, 0);
    chk("twocol_valid", int'(kif.key_valid), 0);

    // Held key 5 with a two-sample release glitch
    hold_until_valid(12'h010);
    p0 = press_seen; r0 = release_seen;
    run_dwell(1'b0, 3'b111, 12'h000);
    run_dwell(1'b0, 3'b111, 12'h000);
    run_dwell(1'b0, 3'b111, 12'h010);
    chk("glitch_valid", int'(kif.key_valid), 1);
    chk("glitch_code", int'(kif.key_code), 5);
    chk("glitch_no_press", press_seen - p0, 0);
    chk("glitch_no_release", release_seen - r0, 0);
    for (int i = 0; i < 3; i++) run_dwell(1'b0, 3'b111, 12'h000);
    chk("glitch_release", release_seen - r0, 1);
    chk("glitch_valid_low", int'(kif.key_valid), 0);

    // Randomized key activity against the reference model
    d = 0;
    while (d < 160) begin
      sel = $urandom_range(0, 9);
      if (sel < 6) mask = 12'(1 << $urandom_range(0, 11));
      else if (sel < 8) mask = 12'h000;
      else mask = 12'(1 << $urandom_range(0, 11)) | 12'(1 << $urandom_range(0, 11));
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        if (sel == 9 && j == 0) run_dwell(1'b1, 3'($urandom_range(0, 7)), mask);
        else run_dwell(1'b0, 3'b111, mask);
        d++;
      end
    end
    release_all();

    // Asynchronous reset while a key is held
    hold_until_valid(12'h010);
    r0 = release_seen;
    chk("pre_reset_valid", int'(kif.key_valid), 1);
    #3;
    reset = 1'b0;
    #1;
    chk("areset_valid", int'(kif.key_valid), 0);
    chk("areset_key_clk", int'(kif.key_clk), 0);
    chk("areset_star", int'(kif.star_pressed), 0);
    chk("areset_row", int'(kif.row), 4'b1110);
    chk("areset_code", int'(kif.key_code), 0);
    key_mask = 12'h000;
    repeat (3) begin
      @(negedge clk);
      if (kif.key_release) release_seen++;
    end
    chk("areset_no_release", release_seen - r0, 0);
    reset = 1'b1;
    model_reset();
    chk("post_reset_row", int'(kif.row), 4'b1110);
    run_dwell(1'b0, 3'b111, 12'h000);
    hold_until_valid(12'h800);
    chk("post_reset_code", int'(kif.key_code), 11);
    release_all();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
